// File: rtl/cam_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cam_bank_scheduler
// Description : Hands the camera frame-buffer RAM banks to the camera packer
//               one at a time. Each accepted word produces a registered
//               one-hot bank write enable, address and data. Tracks bank
//               ownership (FREE -> FILL -> FULL -> FREE) and counts words
//               dropped while no bank is available.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_bank_scheduler #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 512,
  parameter int ADDR_W     = 9,
  parameter int DROP_W     = 16
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RSTn_i,
  input  logic                 sched_en_i,
  input  logic                 cam_frame_i,
  input  logic                 cam_req_i,
  input  logic [31:0]          cam_dat_i,
  output logic [NUM_BANKS-1:0] ram_wen_o,
  output logic [ADDR_W-1:0]    ram_wa_o,
  output logic [31:0]          ram_wd_o,
  input  logic                 rel_i,
  input  logic [NUM_BANKS-1:0] rel_mask_i,
  output logic [NUM_BANKS-1:0] bank_full_o,
  output logic [1:0]           fill_ptr_o,
  output logic [1:0]           state_o,
  output logic                 drop_o,
  output logic [DROP_W-1:0]    drop_cnt_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);
  localparam logic [1:0]        LAST_PTR  = 2'(NUM_BANKS - 1);

  state_t                state, state_nxt;
  logic [NUM_BANKS-1:0]  full, full_nxt;
  logic [1:0]            ptr, ptr_nxt, ptr_inc;
  logic [ADDR_W-1:0]     addr, addr_nxt;
  logic [DROP_W-1:0]     drop_cnt, drop_cnt_nxt;
  logic [NUM_BANKS-1:0]  sel, sel_inc, full_rel;
  logic                  wr_go;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  drop_go;

  // Bank decode and release: released banks are seen as FREE by every
  // decision made in the same cycle.
  always_comb begin
    ptr_inc  = (ptr == LAST_PTR) ? 2'd0 : ptr + 2'd1;
    sel      = NUM_BANKS'(1) << ptr;
    sel_inc  = NUM_BANKS'(1) << ptr_inc;
    full_rel = rel_i ? (full & ~rel_mask_i) : full;
  end

  // Next-state, write and drop decisions.
  always_comb begin
    state_nxt    = state;
    full_nxt     = full_rel;
    ptr_nxt      = ptr;
    addr_nxt     = addr;
    drop_cnt_nxt = drop_cnt;
    wr_go        = 1'b0;
    wr_addr      = addr;
    drop_go      = 1'b0;
    if (!sched_en_i) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          addr_nxt = '0;
          if (cam_frame_i) begin
            state_nxt = (|(full_rel & sel)) ? WAIT : FILL;
          end
        end
        FILL: begin
          // A frame start rewinds the current bank before any word lands.
          wr_addr  = cam_frame_i ? '0 : addr;
          addr_nxt = wr_addr;
          if (cam_req_i) begin
            wr_go = 1'b1;
            if (wr_addr == LAST_ADDR) begin
              // Completion is applied after release so it always wins.
              full_nxt  = full_rel | sel;
              ptr_nxt   = ptr_inc;
              addr_nxt  = '0;
              state_nxt = (|(full_rel & sel_inc)) ? WAIT : FILL;
            end else begin
              addr_nxt = wr_addr + ADDR_W'(1);
            end
          end
        end
        WAIT: begin
          if (cam_req_i) begin
            drop_go = 1'b1;
            if (drop_cnt != '1) begin
              drop_cnt_nxt = drop_cnt + DROP_W'(1);
            end
          end
          state_nxt = (|(full_rel & sel)) ? WAIT : FILL;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Scheduler state registers.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      state    <= IDLE;
      full     <= '0;
      ptr      <= 2'd0;
      addr     <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      full     <= full_nxt;
      ptr      <= ptr_nxt;
      addr     <= addr_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  // Registered RAM write port and drop pulse.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      ram_wen_o <= '0;
      ram_wa_o  <= '0;
      ram_wd_o  <= '0;
      drop_o    <= 1'b0;
    end else begin
      ram_wen_o <= wr_go ? sel : '0;
      drop_o    <= drop_go;
      if (wr_go) begin
        ram_wa_o <= wr_addr;
        ram_wd_o <= cam_dat_i;
      end
    end
  end

  assign bank_full_o = full;
  assign fill_ptr_o  = ptr;
  assign state_o     = state;
  assign drop_cnt_o  = drop_cnt;
  assign irq_o       = |full;

endmodule
`default_nettype wire

// File: tb/tb_cam_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_bank_scheduler
// Description : Self-checking bench for cam_bank_scheduler with a bank
//               ownership reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_bank_scheduler;

  localparam int OWN_FREE = 0;
  localparam int OWN_CAM  = 1;
  localparam int OWN_FULL = 2;

  logic        clk;
  logic        rst_n;
  logic        en, frame, req, rel;
  logic [31:0] dat;
  logic [3:0]  mask;
  logic [3:0]  ram_wen_o;
  logic [8:0]  ram_wa_o;
  logic [31:0] ram_wd_o;
  logic [3:0]  bank_full_o;
  logic [1:0]  fill_ptr_o;
  logic [1:0]  state_o;
  logic        drop_o;
  logic [15:0] drop_cnt_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  // reference model
  int          owner [4];
  int          m_ptr, m_addr, m_state, m_cnt;
  logic [3:0]  e_wen;
  logic [8:0]  e_wa;
  logic [31:0] e_wd;
  logic        e_drop;
  logic [29:0] exp_st;
  logic [29:0] obs;

  cam_bank_scheduler dut (
    .WBs_CLK_i   (clk),
    .WBs_RSTn_i  (rst_n),
    .sched_en_i  (en),
    .cam_frame_i (frame),
    .cam_req_i   (req),
    .cam_dat_i   (dat),
    .ram_wen_o   (ram_wen_o),
    .ram_wa_o    (ram_wa_o),
    .ram_wd_o    (ram_wd_o),
    .rel_i       (rel),
    .rel_mask_i  (mask),
    .bank_full_o (bank_full_o),
    .fill_ptr_o  (fill_ptr_o),
    .state_o     (state_o),
    .drop_o      (drop_o),
    .drop_cnt_o  (drop_cnt_o),
    .irq_o       (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {ram_wen_o, drop_o, bank_full_o, fill_ptr_o, state_o, drop_cnt_o, irq_o};

  function automatic logic [3:0] m_full();
    logic [3:0] f;
    f = 4'b0;
    for (int b = 0; b < 4; b++) f[b] = (owner[b] == OWN_FULL);
    return f;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) owner[b] = OWN_FREE;
    m_ptr = 0; m_addr = 0; m_state = 0; m_cnt = 0;
    e_wen = 4'b0; e_wa = 9'b0; e_wd = 32'b0; e_drop = 1'b0;
    exp_st = 30'b0;
  endtask

  // Advances the ownership model by one clock of the given inputs.
  task automatic model_step(input logic s_en, input logic s_frame, input logic s_req,
                            input logic [31:0] s_dat, input logic s_rel, input logic [3:0] s_mask);
    logic [3:0] f;
    e_wen  = 4'b0;
    e_drop = 1'b0;
    if (s_rel)
      for (int b = 0; b < 4; b++)
        if (s_mask[b] && owner[b] == OWN_FULL) owner[b] = OWN_FREE;
    if (!s_en) begin
      if (m_state == 1) owner[m_ptr] = OWN_FREE;
      m_state = 0;
      m_addr  = 0;
    end else if (m_state == 0) begin
      if (s_frame) begin
        if (owner[m_ptr] == OWN_FREE) begin
          m_state = 1; owner[m_ptr] = OWN_CAM;
        end else begin
          m_state = 2;
        end
      end
    end else if (m_state == 1) begin
      if (s_frame) m_addr = 0;
      if (s_req) begin
        e_wen = 4'(1 << m_ptr);
        e_wa  = 9'(m_addr);
        e_wd  = s_dat;
        m_addr++;
        if (m_addr == 512) begin
          owner[m_ptr] = OWN_FULL;
          m_ptr  = (m_ptr + 1) % 4;
          m_addr = 0;
          if (owner[m_ptr] == OWN_FREE) owner[m_ptr] = OWN_CAM;
          else m_state = 2;
        end
      end
    end else begin
      if (s_req) begin
        e_drop = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
      if (owner[m_ptr] == OWN_FREE) begin
        m_state = 1; owner[m_ptr] = OWN_CAM;
      end
    end
    f = m_full();
    exp_st = {e_wen, e_drop, f, 2'(m_ptr), 2'(m_state), 16'(m_cnt), |f};
  endtask

  task automatic step(input logic s_en, input logic s_frame, input logic s_req,
                      input logic [31:0] s_dat, input logic s_rel, input logic [3:0] s_mask);
    en = s_en; frame = s_frame; req = s_req; dat = s_dat; rel = s_rel; mask = s_mask;
    model_step(s_en, s_frame, s_req, s_dat, s_rel, s_mask);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; frame = 0; req = 0; dat = 0; rel = 0; mask = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({obs, ram_wa_o, ram_wd_o} !== 71'b0)
      begin errors++; $display("FAIL reset_outputs: got %h required 0", {obs, ram_wa_o, ram_wd_o}); end
  endtask

  task automatic test_fill_first_bank();
    logic [31:0] d;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 512; i++) begin
      d = $urandom;
      step(1, 0, 1, d, 0, 0);
      checks++;
      if (obs !== exp_st || ram_wa_o !== e_wa || ram_wd_o !== e_wd)
        begin errors++; $display("FAIL fill0 word %0d: got %h/%h/%h required %h/%h/%h", i, obs, ram_wa_o, ram_wd_o, exp_st, e_wa, e_wd); end
    end
    checks++;
    if (bank_full_o !== 4'b0001 || irq_o !== 1'b1)
      begin errors++; $display("FAIL bank0_full: got full=%b irq=%b required 0001/1", bank_full_o, irq_o); end
    step(1, 0, 1, 32'h1234_5678, 0, 0);
    checks++;
    if (ram_wen_o !== 4'b0010 || ram_wa_o !== 9'd0)
      begin errors++; $display("FAIL word513: got wen=%b wa=%0d required 0010/0", ram_wen_o, ram_wa_o); end
  endtask

  task automatic test_wait_drops();
    for (int i = 0; i < 1535; i++) step(1, 0, 1, $urandom, 0, 0);
    checks++;
    if (obs !== exp_st || state_o !== 2'd2 || bank_full_o !== 4'b1111)
      begin errors++; $display("FAIL all_full: got %h state=%0d required %h state=2", obs, state_o, exp_st); end
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, $urandom, 0, 0);
      checks++;
      if (drop_o !== 1'b1 || ram_wen_o !== 4'b0 || obs !== exp_st)
        begin errors++; $display("FAIL drop %0d: got drop=%b wen=%b required 1/0000", i, drop_o, ram_wen_o); end
    end
    checks++;
    if (drop_cnt_o !== 16'd10)
      begin errors++; $display("FAIL drop_cnt10: got %0d required 10", drop_cnt_o); end
  endtask

  task automatic test_release_in_wait();
    step(1, 0, 0, 0, 1, 4'b0001);
    checks++;
    if (state_o !== 2'd1 || fill_ptr_o !== 2'd0 || bank_full_o !== 4'b1110)
      begin errors++; $display("FAIL release_wait: got state=%0d ptr=%0d full=%b required 1/0/1110", state_o, fill_ptr_o, bank_full_o); end
    step(1, 0, 1, 32'hCAFE_0001, 0, 0);
    checks++;
    if (ram_wen_o !== 4'b0001 || ram_wa_o !== 9'd0 || ram_wd_o !== 32'hCAFE_0001)
      begin errors++; $display("FAIL release_write: got wen=%b wa=%0d wd=%h required 0001/0/cafe0001", ram_wen_o, ram_wa_o, ram_wd_o); end
  endtask

  task automatic test_release_on_completion();
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2047; i++) step(1, 0, 1, $urandom, 0, 0);
    step(1, 0, 1, 32'hBEEF_0511, 1, 4'b1001);
    checks++;
    if (bank_full_o !== 4'b1110 || state_o !== 2'd1 || fill_ptr_o !== 2'd0 || drop_o !== 1'b0 ||
        ram_wen_o !== 4'b1000 || ram_wa_o !== 9'd511)
      begin errors++; $display("FAIL release_completion: got full=%b state=%0d ptr=%0d drop=%b wen=%b wa=%0d required 1110/1/0/0/1000/511",
                               bank_full_o, state_o, fill_ptr_o, drop_o, ram_wen_o, ram_wa_o); end
    step(1, 0, 1, 32'h0000_0AAA, 0, 0);
    checks++;
    if (ram_wen_o !== 4'b0001 || drop_o !== 1'b0 || obs !== exp_st)
      begin errors++; $display("FAIL after_completion: got wen=%b drop=%b required 0001/0", ram_wen_o, drop_o); end
  endtask

  task automatic test_frame_restart();
    logic [31:0] d;
    for (int i = 0; i < 99; i++) step(1, 0, 1, $urandom, 0, 0);
    checks++;
    if (ram_wa_o !== 9'd99 || obs !== exp_st)
      begin errors++; $display("FAIL pre_frame: got wa=%0d required 99", ram_wa_o); end
    d = $urandom;
    step(1, 1, 1, d, 0, 0);
    checks++;
    if (ram_wen_o !== 4'b0001 || ram_wa_o !== 9'd0 || ram_wd_o !== d)
      begin errors++; $display("FAIL frame_req: got wen=%b wa=%0d wd=%h required 0001/0/%h", ram_wen_o, ram_wa_o, ram_wd_o, d); end
  endtask

  task automatic test_disable();
    step(0, 0, 1, 32'h5555_5555, 0, 0);
    checks++;
    if (state_o !== 2'd0 || ram_wen_o !== 4'b0 || bank_full_o !== 4'b1110 || obs !== exp_st)
      begin errors++; $display("FAIL disable: got state=%0d wen=%b full=%b required 0/0000/1110", state_o, ram_wen_o, bank_full_o); end
    step(1, 0, 1, 32'h6666_6666, 0, 0);
    checks++;
    if (state_o !== 2'd0 || ram_wen_o !== 4'b0 || drop_o !== 1'b0)
      begin errors++; $display("FAIL idle_req: got state=%0d wen=%b drop=%b required 0/0000/0", state_o, ram_wen_o, drop_o); end
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h7777_7777, 0, 0);
    checks++;
    if (ram_wen_o !== 4'b0001 || ram_wa_o !== 9'd0)
      begin errors++; $display("FAIL reenable: got wen=%b wa=%0d required 0001/0", ram_wen_o, ram_wa_o); end
  endtask

  task automatic test_random();
    logic s_en, s_frame, s_req, s_rel;
    int   bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      s_en    = ($urandom_range(0, 1999) != 0);
      s_frame = (m_state == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1999) == 0);
      s_req   = ($urandom_range(0, 3) != 0);
      s_rel   = ($urandom_range(0, 59) == 0);
      step(s_en, s_frame, s_req, $urandom, s_rel, 4'($urandom));
      checks++;
      if (obs !== exp_st || (e_wen != 4'b0 && (ram_wa_o !== e_wa || ram_wd_o !== e_wd))) begin
        errors++;
        if (bad < 10)
          $display("FAIL random cyc %0d: got %h wa=%0d wd=%h required %h wa=%0d wd=%h", i, obs, ram_wa_o, ram_wd_o, exp_st, e_wa, e_wd);
        bad++;
      end
    end
  endtask

  task automatic test_saturate_and_async_reset();
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2048; i++) step(1, 0, 1, $urandom, 0, 0);
    for (int i = 0; i < 65540; i++) step(1, 0, 1, $urandom, 0, 0);
    checks++;
    if (drop_cnt_o !== 16'hFFFF || drop_o !== 1'b1 || obs !== exp_st)
      begin errors++; $display("FAIL saturate: got cnt=%h drop=%b required ffff/1", drop_cnt_o, drop_o); end
    step(1, 0, 0, 0, 1, 4'b0001);
    for (int i = 0; i < 5; i++) step(1, 0, 1, $urandom, 0, 0);
    checks++;
    if (ram_wen_o !== 4'b0001 || ram_wa_o !== 9'd4 || obs !== exp_st)
      begin errors++; $display("FAIL mid_fill: got wen=%b wa=%0d required 0001/4", ram_wen_o, ram_wa_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, ram_wa_o, ram_wd_o} !== 71'b0)
      begin errors++; $display("FAIL async_reset: got %h required 0", {obs, ram_wa_o, ram_wd_o}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1;
    en = 0; frame = 0; req = 0; dat = 0; rel = 0; mask = 0;
    model_reset();
    test_reset();
    test_fill_first_bank();
    test_wait_drops();
    test_release_in_wait();
    test_release_on_completion();
    test_frame_restart();
    test_disable();
    test_random();
    test_saturate_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
